// File: rtl/key_voice_alloc.sv
// PS/2 scancode to tone-voice allocator: tracks held keys across NCH voices,
// steals round-robin when full, and reports the newest held key as mono_inc.
module key_voice_alloc #(
  parameter int NCH   = 4,
  parameter int INC_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   code_valid,
  input  logic [7:0]             code,
  output logic                   code_ready,
  output logic [NCH*INC_W-1:0]   voice_inc,
  output logic [NCH-1:0]         voice_on,
  output logic [INC_W-1:0]       mono_inc,
  output logic [3:0]             key_count
);

  localparam int VW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t         state;
  logic           brk, ext;
  logic           p_brk, p_ext;
  logic [7:0]     p_code;
  logic [VW-1:0]  steal_ptr, last;
  logic [2:0]     kidx [NCH];

  // {mapped, key index}
  function automatic logic [3:0] lookup(input logic [7:0] c);
    case (c)
      8'h15:   lookup = 4'b1_000;
      8'h1D:   lookup = 4'b1_001;
      8'h24:   lookup = 4'b1_010;
      8'h2D:   lookup = 4'b1_011;
      8'h2C:   lookup = 4'b1_100;
      8'h35:   lookup = 4'b1_101;
      8'h3C:   lookup = 4'b1_110;
      8'h43:   lookup = 4'b1_111;
      default: lookup = 4'b0_000;
    endcase
  endfunction

  function automatic logic [15:0] base_inc(input logic [2:0] k);
    case (k)
      3'd0:    base_inc = 16'd714;
      3'd1:    base_inc = 16'd802;
      3'd2:    base_inc = 16'd900;
      3'd3:    base_inc = 16'd954;
      3'd4:    base_inc = 16'd1070;
      3'd5:    base_inc = 16'd1201;
      3'd6:    base_inc = 16'd1349;
      default: base_inc = 16'd1429;
    endcase
  endfunction

  logic             map_hit;
  logic [2:0]       k;
  logic [INC_W-1:0] k_inc;
  logic             held, free;
  logic [VW-1:0]    held_v, free_v, tgt;

  assign {map_hit, k} = lookup(p_code);
  assign k_inc = INC_W'(base_inc(k)) << (INC_W - 16);

  // Descending scan so the lowest matching index wins.
  always_comb begin
    held   = 1'b0;
    held_v = '0;
    free   = 1'b0;
    free_v = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (voice_on[i] && kidx[i] == k) begin
        held   = 1'b1;
        held_v = VW'(i);
      end
      if (!voice_on[i]) begin
        free   = 1'b1;
        free_v = VW'(i);
      end
    end
  end

  assign tgt = free ? free_v : steal_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      code_ready <= 1'b1;
      brk        <= 1'b0;
      ext        <= 1'b0;
      p_brk      <= 1'b0;
      p_ext      <= 1'b0;
      p_code     <= '0;
      steal_ptr  <= '0;
      last       <= '0;
      voice_on   <= '0;
      voice_inc  <= '0;
      mono_inc   <= '0;
      key_count  <= '0;
      for (int i = 0; i < NCH; i++) kidx[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (code_valid && code_ready) begin
            if (code == 8'hF0) begin
              brk <= 1'b1;
            end else if (code == 8'hE0) begin
              ext <= 1'b1;
            end else begin
              p_code     <= code;
              p_brk      <= brk;
              p_ext      <= ext;
              brk        <= 1'b0;
              ext        <= 1'b0;
              state      <= UPDATE;
              code_ready <= 1'b0;
            end
          end
        end
        UPDATE: begin
          state      <= IDLE;
          code_ready <= 1'b1;
          if (map_hit && !p_ext) begin
            if (p_brk) begin
              if (held) begin
                voice_on[held_v]                <= 1'b0;
                voice_inc[held_v*INC_W +: INC_W] <= '0;
                key_count                       <= key_count - 4'd1;
                if (last == held_v) mono_inc <= '0;
              end
            end else if (!held) begin
              voice_on[tgt]                <= 1'b1;
              voice_inc[tgt*INC_W +: INC_W] <= k_inc;
              kidx[tgt]                    <= k;
              mono_inc                     <= k_inc;
              last                         <= tgt;
              if (free)
                key_count <= key_count + 4'd1;
              else if (steal_ptr == VW'(NCH - 1))
                steal_ptr <= '0;
              else
                steal_ptr <= steal_ptr + 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          code_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_voice_alloc.sv
// Bench for key_voice_alloc: directed scenarios plus random scancode traffic
// compared every cycle against a behavioural voice-pool model.
module tb_key_voice_alloc;
  localparam int NCH   = 4;
  localparam int INC_W = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 code_valid;
  logic [7:0]           code;
  logic                 code_ready;
  logic [NCH*INC_W-1:0] voice_inc;
  logic [NCH-1:0]       voice_on;
  logic [INC_W-1:0]     mono_inc;
  logic [3:0]           key_count;

  key_voice_alloc #(.NCH(NCH), .INC_W(INC_W)) dut (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
    .code_ready(code_ready), .voice_inc(voice_inc), .voice_on(voice_on),
    .mono_inc(mono_inc), .key_count(key_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: voices keyed by scancode, increments from a lookup table.
  int tbl[int];
  bit m_on[NCH];
  int m_key[NCH];
  int m_inc[NCH];
  int m_steal, m_last, m_mono;
  bit m_rdy, m_brk, m_ext, m_pend;
  int p_code;
  bit p_brk, p_ext;

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_on[i] = 0; m_key[i] = -1; m_inc[i] = 0;
    end
    m_steal = 0; m_last = 0; m_mono = 0;
    m_rdy = 1; m_brk = 0; m_ext = 0; m_pend = 0;
  endtask

  task automatic m_apply();
    int h;
    int v;
    if (p_ext || !tbl.exists(p_code)) return;
    h = -1;
    for (int i = 0; i < NCH; i++)
      if (m_on[i] && m_key[i] == p_code) h = i;
    if (p_brk) begin
      if (h >= 0) begin
        m_on[h] = 0;
        m_inc[h] = 0;
        if (m_last == h) m_mono = 0;
      end
      return;
    end
    if (h >= 0) return;
    v = -1;
    for (int i = NCH - 1; i >= 0; i--)
      if (!m_on[i]) v = i;
    if (v < 0) begin
      v = m_steal;
      m_steal = (m_steal + 1) % NCH;
    end
    m_on[v] = 1;
    m_key[v] = p_code;
    m_inc[v] = tbl[p_code] << (INC_W - 16);
    m_mono = m_inc[v];
    m_last = v;
  endtask

  task automatic compare();
    logic [NCH*INC_W-1:0] e_inc;
    logic [NCH-1:0]       e_on;
    int                   cnt;
    cnt = 0;
    for (int i = 0; i < NCH; i++) begin
      e_on[i] = m_on[i];
      e_inc[i*INC_W +: INC_W] = INC_W'(m_inc[i]);
      cnt += int'(m_on[i]);
    end
    chk("ready", 64'(code_ready), 64'(m_rdy));
    chk("voice_on", 64'(voice_on), 64'(e_on));
    chk("voice_inc", 64'(voice_inc), 64'(e_inc));
    chk("mono_inc", 64'(mono_inc), 64'(m_mono));
    chk("key_count", 64'(key_count), 64'(cnt));
  endtask

  task automatic step(bit r, bit v, logic [7:0] c);
    @(negedge clk);
    rst = r; code_valid = v; code = c;
    @(posedge clk);
    if (r) begin
      m_reset();
    end else if (m_pend) begin
      m_apply();
      m_pend = 0;
      m_rdy = 1;
    end else if (m_rdy && v) begin
      if (c == 8'hF0) m_brk = 1;
      else if (c == 8'hE0) m_ext = 1;
      else begin
        p_code = int'(c); p_brk = m_brk; p_ext = m_ext;
        m_brk = 0; m_ext = 0;
        m_pend = 1; m_rdy = 0;
      end
    end
    #1 compare();
  endtask

  task automatic send(logic [7:0] c);
    step(0, 1, c);
    step(0, 0, 8'h00);
  endtask

  task automatic do_reset();
    step(1, 0, 8'h00);
    step(1, 1, 8'h15);
  endtask

  logic [7:0] pool [13] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35,
                            8'h3C, 8'h43, 8'hF0, 8'hF0, 8'hE0, 8'h0F, 8'h77};

  initial begin
    tbl[8'h15] = 714;  tbl[8'h1D] = 802;  tbl[8'h24] = 900;
    tbl[8'h2D] = 954;  tbl[8'h2C] = 1070; tbl[8'h35] = 1201;
    tbl[8'h3C] = 1349; tbl[8'h43] = 1429;
    rst = 1; code_valid = 0; code = 0;
    m_reset();

    do_reset();
    chk("rst_ready", 64'(code_ready), 64'd1);
    chk("rst_on", 64'(voice_on), 64'd0);
    send(8'h15);
    chk("single_inc0", 64'(voice_inc[15:0]), 64'd714);
    chk("single_mono", 64'(mono_inc), 64'd714);

    do_reset();
    send(8'h15); send(8'h1D); send(8'h24);
    send(8'hF0); send(8'h1D);
    chk("brk_count", 64'(key_count), 64'd2);
    chk("brk_mono", 64'(mono_inc), 64'd900);
    send(8'hF0); send(8'h24);
    chk("brk_last_mono", 64'(mono_inc), 64'd0);
    chk("brk_v0_kept", 64'(voice_inc[15:0]), 64'd714);

    do_reset();
    send(8'h15); send(8'h15); send(8'h15);
    chk("repeat_count", 64'(key_count), 64'd1);

    do_reset();
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    chk("steal_v0", 64'(voice_inc[15:0]), 64'd1070);
    chk("steal_count", 64'(key_count), 64'd4);
    send(8'h35);
    chk("steal_v1", 64'(voice_inc[31:16]), 64'd1201);

    do_reset();
    send(8'hE0); send(8'h15);
    send(8'hE0); send(8'hF0); send(8'h15);
    send(8'h0F); send(8'hF0); send(8'h0F);
    chk("discard_on", 64'(voice_on), 64'd0);

    do_reset();
    step(0, 1, 8'h15);
    step(1, 1, 8'h15);
    step(0, 0, 8'h00);
    chk("upd_rst_on", 64'(voice_on), 64'd0);
    chk("upd_rst_ready", 64'(code_ready), 64'd1);

    do_reset();
    for (int n = 0; n < 4000; n++) begin
      bit r;
      bit v;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) != 0);
      step(r, v, pool[$urandom_range(0, 12)]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
